// File: rtl/ordinator_pkg.sv
// Shared token codes, FSM states and error codes for the ordinator sequence driver.
package ordinator_pkg;

  localparam logic [7:0] OP_ADD = 8'd0;
  localparam logic [7:0] OP_SUB = 8'd1;
  localparam logic [7:0] OP_END = 8'd2;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NO_END  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRST,
    ST_WINIT,
    ST_ISSUE,
    ST_WRES,
    ST_DONE,
    ST_ERR
  } state_t;

  // Operators that hand the next slot back to an operand.
  function automatic logic is_arith_op(input logic [7:0] tok);
    return (tok == OP_ADD) || (tok == OP_SUB);
  endfunction

endpackage

// File: rtl/ordinator_prog_mem.sv
// Token program store: DEPTH x 8 register file, synchronous write, asynchronous read.
module ordinator_prog_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata_c
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/ordinator_seq_driver.sv
// Runs a stored token program against an ordinator_8bit calculator and captures its result.
// Optional golden-model check and mismatch flag: define ORDINATOR_SEQ_CHECK_EN.
module ordinator_seq_driver
  import ordinator_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [7:0]               prog_data,
  input  logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     start,
  output logic [7:0]               calc_in,
  output logic                     calc_reset,
  input  logic                     calc_ready,
  input  logic [7:0]               calc_result,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [7:0]               result_q
`ifdef ORDINATOR_SEQ_CHECK_EN
  ,output logic                    mismatch
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   len_q;
  logic [CW-1:0]   tmo_cnt;
  logic            opslot;
  logic [PW-1:0]   ptr_inc_c;
  logic [AW-1:0]   rd_addr_c;
  logic [7:0]      rd_tok_c;
  logic            tmo_hit_c;
  logic            is_end_c;
  logic            go_err_c;
  logic [1:0]      err_sel_c;

  ordinator_prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we      (prog_we && !busy),
    .waddr   (prog_addr),
    .wdata   (prog_data),
    .raddr   (rd_addr_c),
    .rdata_c (rd_tok_c)
  );

  // Slot 0 is fetched while leaving CRST; afterwards always look one token ahead.
  assign ptr_inc_c = ptr + PW'(1);
  assign rd_addr_c = (state == ST_ISSUE) ? AW'(ptr_inc_c) : '0;
  assign tmo_hit_c = (tmo_cnt == CW'(TIMEOUT - 1));
  assign is_end_c  = opslot && (calc_in == OP_END);

  // Abort conditions: program exhausted without END, or calculator stalled.
  always_comb begin
    err_sel_c = ERR_NONE;
    case (state)
      ST_WINIT: begin
        if (calc_ready) begin
          if (len_q == '0) err_sel_c = ERR_NO_END;
        end else if (tmo_hit_c) begin
          err_sel_c = ERR_TIMEOUT;
        end
      end
      ST_ISSUE: begin
        if (calc_ready) begin
          if (!is_end_c && (ptr_inc_c == len_q)) err_sel_c = ERR_NO_END;
        end else if (tmo_hit_c) begin
          err_sel_c = ERR_TIMEOUT;
        end
      end
      ST_WRES: begin
        if (!calc_ready && tmo_hit_c) err_sel_c = ERR_TIMEOUT;
      end
      default: err_sel_c = ERR_NONE;
    endcase
    go_err_c = (err_sel_c != ERR_NONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      len_q      <= '0;
      tmo_cnt    <= '0;
      opslot     <= 1'b0;
      calc_in    <= '0;
      calc_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      result_q   <= '0;
    end else begin
      done <= 1'b0;
      if (go_err_c) begin
        state      <= ST_ERR;
        error      <= 1'b1;
        err_code   <= err_sel_c;
        calc_reset <= 1'b1;
        busy       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state      <= ST_CRST;
              busy       <= 1'b1;
              error      <= 1'b0;
              err_code   <= ERR_NONE;
              calc_reset <= 1'b1;
              ptr        <= '0;
              len_q      <= prog_len;
            end
          end
          ST_CRST: begin
            state      <= ST_WINIT;
            calc_reset <= 1'b0;
            calc_in    <= rd_tok_c;
            tmo_cnt    <= '0;
            opslot     <= 1'b0;
          end
          ST_WINIT: begin
            if (calc_ready) begin
              state   <= ST_ISSUE;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + CW'(1);
            end
          end
          ST_ISSUE: begin
            if (calc_ready) begin
              ptr     <= ptr_inc_c;
              calc_in <= rd_tok_c;
              tmo_cnt <= '0;
              if (is_end_c) state <= ST_WRES;
              // Invalid operators leave the slot type unchanged.
              if (!opslot) opslot <= 1'b1;
              else if (is_arith_op(calc_in)) opslot <= 1'b0;
            end else begin
              tmo_cnt <= tmo_cnt + CW'(1);
            end
          end
          ST_WRES: begin
            if (calc_ready) begin
              result_q <= calc_result;
              state    <= ST_DONE;
            end else begin
              tmo_cnt <= tmo_cnt + CW'(1);
            end
          end
          ST_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          ST_ERR:  state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef ORDINATOR_SEQ_CHECK_EN
  logic [7:0] acc;
  logic       acc_vld;
  logic       pend_sub;

  // Golden accumulator fed from the same handshakes the calculator sees.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      acc_vld  <= 1'b0;
      pend_sub <= 1'b0;
      mismatch <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      acc_vld  <= 1'b0;
      pend_sub <= 1'b0;
      mismatch <= 1'b0;
    end else if ((state == ST_ISSUE) && calc_ready) begin
      if (!opslot) begin
        acc_vld <= 1'b1;
        if (!acc_vld)     acc <= calc_in;
        else if (pend_sub) acc <= acc - calc_in;
        else               acc <= acc + calc_in;
      end else if (calc_in == OP_ADD) begin
        pend_sub <= 1'b0;
      end else if (calc_in == OP_SUB) begin
        pend_sub <= 1'b1;
      end
    end else if (state == ST_DONE) begin
      mismatch <= (result_q != acc);
    end
  end
`endif

endmodule

// File: tb/tb_ordinator_seq_driver.sv
// Bench for ordinator_seq_driver with a behavioural ordinator_8bit stand-in and a result scoreboard.
module tb_ordinator_seq_driver;
  import ordinator_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [4:0] prog_len = '0;
  logic       start = 1'b0;
  logic [7:0] calc_in;
  logic       calc_reset;
  logic       calc_ready = 1'b0;
  logic [7:0] calc_result = '0;
  logic       busy, done, error;
  logic [1:0] err_code;
  logic [7:0] result_q;
  logic       mismatch;

  logic       start_t = 1'b0;
  logic [7:0] calc_in_t;
  logic       calc_reset_t, busy_t, done_t, error_t;
  logic [1:0] err_code_t;
  logic [7:0] result_q_t;
  logic       mismatch_t;

  ordinator_seq_driver #(.DEPTH(16), .TIMEOUT(255)) dut (
`ifdef ORDINATOR_SEQ_CHECK_EN
    .mismatch(mismatch),
`endif
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .calc_in(calc_in),
    .calc_reset(calc_reset), .calc_ready(calc_ready), .calc_result(calc_result),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .result_q(result_q)
  );

  ordinator_seq_driver #(.DEPTH(16), .TIMEOUT(20)) dut_t (
`ifdef ORDINATOR_SEQ_CHECK_EN
    .mismatch(mismatch_t),
`endif
    .clk(clk), .reset(reset), .prog_we(1'b0), .prog_addr(4'd0),
    .prog_data(8'd0), .prog_len(5'd4), .start(start_t), .calc_in(calc_in_t),
    .calc_reset(calc_reset_t), .calc_ready(1'b0), .calc_result(8'd0),
    .busy(busy_t), .done(done_t), .error(error_t), .err_code(err_code_t), .result_q(result_q_t)
  );

`ifndef ORDINATOR_SEQ_CHECK_EN
  assign mismatch   = 1'b0;
  assign mismatch_t = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Calculator stand-in: one ready on reset exit (initial state), then one token per ready.
  typedef enum {C_INIT, C_RUN, C_RES, C_IDLE} cst_t;
  cst_t       c_st = C_IDLE;
  logic       c_opslot, c_first, c_sub;
  logic [7:0] c_acc;
  int         c_wait;

  always @(posedge clk) begin
    if (calc_reset) begin
      c_st <= C_INIT; calc_ready <= 1'b1; c_wait <= 0;
      c_opslot <= 1'b0; c_first <= 1'b1; c_sub <= 1'b0; c_acc <= '0; calc_result <= '0;
    end else if (calc_ready) begin
      calc_ready <= 1'b0;
      c_wait <= int'($urandom_range(2, 0));
      case (c_st)
        C_INIT: c_st <= C_RUN;
        C_RUN: begin
          if (!c_opslot) begin
            c_opslot <= 1'b1; c_first <= 1'b0;
            if (c_first)    c_acc <= calc_in;
            else if (c_sub) c_acc <= c_acc - calc_in;
            else            c_acc <= c_acc + calc_in;
          end else if (calc_in == 8'd2) begin
            c_st <= C_RES; calc_result <= c_acc;
          end else if (calc_in == 8'd0) begin
            c_sub <= 1'b0; c_opslot <= 1'b0;
          end else if (calc_in == 8'd1) begin
            c_sub <= 1'b1; c_opslot <= 1'b0;
          end
        end
        C_RES:   c_st <= C_IDLE;
        default: ;
      endcase
    end else if (c_st != C_IDLE) begin
      if (c_wait == 0) calc_ready <= 1'b1;
      else c_wait <= c_wait - 1;
    end
  end

  typedef logic [7:0] tok_q_t [$];
  typedef struct {
    string      name;
    logic [7:0] toks [16];
    int         len;
    logic       exp_err;
    logic [1:0] exp_code;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs [$];
  vec_t sb [$];

  task automatic add_vec(input string nm, input tok_q_t t, input int len,
                         input logic e, input logic [1:0] c, input logic [7:0] r);
    vec_t v;
    v.name = nm; v.len = len; v.exp_err = e; v.exp_code = c; v.exp_res = r;
    for (int i = 0; i < 16; i++) v.toks[i] = (i < t.size()) ? t[i] : 8'd0;
    vecs.push_back(v);
  endtask

  // Scoreboard: each done or rising error consumes one expected outcome.
  logic err_d = 1'b0;
  always @(negedge clk) begin
    vec_t e;
    if (reset) begin
      err_d = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got result %0d, expected no done", result_q);
        end else begin
          e = sb.pop_front();
          check({e.name, "_err_at_done"}, 32'(error), 32'(e.exp_err));
          check({e.name, "_result"}, 32'(result_q), 32'(e.exp_res));
          check({e.name, "_busy_at_done"}, 32'(busy), 32'd0);
          check({e.name, "_calc_reset_at_done"}, 32'(calc_reset), 32'd0);
`ifdef ORDINATOR_SEQ_CHECK_EN
          check({e.name, "_mismatch"}, 32'(mismatch), 32'd0);
`endif
        end
      end
      if (error && !err_d) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_error: got code %0d, expected no error", err_code);
        end else begin
          e = sb.pop_front();
          check({e.name, "_err"}, 32'(error), 32'(e.exp_err));
          check({e.name, "_err_code"}, 32'(err_code), 32'(e.exp_code));
          check({e.name, "_calc_reset_on_err"}, 32'(calc_reset), 32'd1);
          check({e.name, "_done_on_err"}, 32'(done), 32'd0);
        end
      end
      err_d = error;
    end
  end

  task automatic load_prog(input vec_t v);
    @(negedge clk); prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'hEE;
    for (int i = 1; i < v.len && i < 16; i++) begin
      @(negedge clk); prog_addr = 4'(i); prog_data = v.toks[i];
    end
    @(negedge clk); prog_we = 1'b0;
  endtask

  // Slot 0 is written in the same cycle as start: the run must see the new value.
  task automatic start_prog(input vec_t v, input logic expect_outcome);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = v.toks[0];
    prog_len = 5'(v.len); start = 1'b1;
    if (expect_outcome) sb.push_back(v);
    @(negedge clk); prog_we = 1'b0; start = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int c = 0; c < 600 && sb.size() != 0; c++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got %0d outstanding, expected 0", nm, sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int dc;
    add_vec("add",      '{8'd10, 8'd0, 8'd12, 8'd2}, 4, 1'b0, ERR_NONE, 8'd22);
    add_vec("sub",      '{8'd10, 8'd1, 8'd12, 8'd2}, 4, 1'b0, ERR_NONE, 8'd254);
    add_vec("invalid",  '{8'd10, 8'd5, 8'd0, 8'd12, 8'd15, 8'd8, 8'd1, 8'd34, 8'd0, 8'd7, 8'd2},
            11, 1'b0, ERR_NONE, 8'd251);
    add_vec("no_end",   '{8'd10, 8'd0, 8'd12}, 3, 1'b1, ERR_NO_END, 8'd0);
    add_vec("len0",     '{8'd10}, 0, 1'b1, ERR_NO_END, 8'd0);
    add_vec("two_opnd", '{8'd2, 8'd0, 8'd2, 8'd2}, 4, 1'b0, ERR_NONE, 8'd4);
    add_vec("wrap",     '{8'd200, 8'd0, 8'd100, 8'd2}, 4, 1'b0, ERR_NONE, 8'd44);
    add_vec("single",   '{8'd5, 8'd2}, 2, 1'b0, ERR_NONE, 8'd5);
    add_vec("full",     '{8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0,
                          8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd2},
            16, 1'b0, ERR_NONE, 8'd8);
    add_vec("bad_op",   '{8'd7, 8'd9}, 2, 1'b1, ERR_NO_END, 8'd0);

    repeat (3) @(negedge clk);
    check("rst_calc_in", 32'(calc_in), 32'd0);
    check("rst_calc_reset", 32'(calc_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_result_q", 32'(result_q), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      load_prog(vecs[i]);
      start_prog(vecs[i], 1'b1);
      drain(vecs[i].name);
    end

    // start and prog_we while busy are ignored; a bare restart reuses the untouched program.
    load_prog(vecs[0]);
    start_prog(vecs[0], 1'b1);
    repeat (2) @(negedge clk);
    check("busy_running", 32'(busy), 32'd1);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'd99; prog_len = 5'd2; start = 1'b1;
    @(negedge clk); prog_we = 1'b0; start = 1'b0; prog_len = 5'd4;
    drain("busy_ignore");
    dc = done_cnt;
    sb.push_back(vecs[0]);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    drain("restart");
    check("restart_done_count", 32'(done_cnt - dc), 32'd1);

    // Reset mid-ISSUE: no stale done, then a clean rerun.
    load_prog(vecs[0]);
    start_prog(vecs[0], 1'b0);
    repeat (3) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_calc_reset", 32'(calc_reset), 32'd1);
    check("midrst_result_q", 32'(result_q), 32'd0);
    dc = done_cnt;
    repeat (30) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - dc), 32'd0);
    check("midrst_no_error", 32'(error), 32'd0);
    load_prog(vecs[0]);
    start_prog(vecs[0], 1'b1);
    drain("rerun");

    // Timeout with calc_ready tied low: ERR exactly TIMEOUT cycles after WINIT entry.
    @(negedge clk); start_t = 1'b1;
    @(posedge clk);
    @(negedge clk); start_t = 1'b0;
    @(posedge clk); #1;
    check("tmo_calc_reset_winit", 32'(calc_reset_t), 32'd0);
    check("tmo_busy_winit", 32'(busy_t), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 19) check("tmo_error_early", 32'(error_t), 32'd0);
    end
    check("tmo_error", 32'(error_t), 32'd1);
    check("tmo_err_code", 32'(err_code_t), 32'(ERR_TIMEOUT));
    check("tmo_calc_reset", 32'(calc_reset_t), 32'd1);
    check("tmo_busy", 32'(busy_t), 32'd0);
    repeat (3) @(posedge clk); #1;
    check("tmo_error_sticky", 32'(error_t), 32'd1);
    check("tmo_calc_reset_idle", 32'(calc_reset_t), 32'd1);
    check("tmo_no_done", 32'(done_t), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ordinator_seq_driver.md
# ordinator_seq_driver

Initiator side of the ordinator token protocol. It holds a small, writable program of 8-bit tokens (operands and operator codes) and issues them one per `ready` handshake to an `ordinator_8bit` instance. It then captures the instance's `result` and reports done or error. The block sits between a host or test harness and the calculator, so expressions can be run back to back without a hand-written stimulus.

## Interface
Parameters:
- `DEPTH`, 16: program memory size in tokens; must be a power of two, at least 2.
- `TIMEOUT`, 255: maximum cycles to wait for `ready` before aborting.

Ports:
- `clk`  in  1: single clock, all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `prog_we`  in  1: program write strobe.
- `prog_addr`  in  log2(DEPTH): program write address.
- `prog_data`  in  8: token to write.
- `prog_len`  in  log2(DEPTH)+1: number of valid tokens, sampled on `start`.
- `start`  in  1: one-cycle pulse that runs the program.
- `calc_in`  out  8: token presented to the calculator `in`.
- `calc_reset`  out  1: drives the calculator `reset`.
- `calc_ready`  in  1: calculator `ready`.
- `calc_result`  in  8: calculator `result`.
- `busy`  out  1: high from `start` accepted until done or error.
- `done`  out  1: one-cycle pulse when the result is captured.
- `error`  out  1: sticky until the next accepted `start`.
- `err_code`  out  2: 0 none, 1 no END token, 2 timeout.
- `result_q`  out  8: captured result.

## Operation
- Token semantics:
  - Slots alternate operand and operator, starting with an operand.
  - Operator codes: 0 add, 1 sub, 2 END.
  - Any other code in an operator slot is invalid. It is still issued, and the slot stays "operator".
  - Operands are raw 8-bit values.
- States:
  - IDLE: accepts `start` when not busy.
  - CRST: `calc_reset`=1 for exactly 1 cycle.
  - WINIT: waits for the first `calc_ready`, the calculator's initial state; no token is consumed.
  - ISSUE: presents tokens.
  - WRES: waits for the result after END.
  - DONE: pulses `done`, then returns to IDLE.
  - ERR: sets `error` and `err_code`, asserts `calc_reset`, then returns to IDLE.
- Handshake:
  - A token is consumed at every rising edge where `calc_ready`=1 in ISSUE.
  - On that edge `ptr` increments and `calc_in` is reloaded with `mem[ptr+1]`.
  - `calc_in` is registered and stable between consumptions.
- END detection: an END token in an operator slot, once consumed, moves ISSUE to WRES. The value 2 in an operand slot is an operand.
- `ptr` reaching `prog_len` in ISSUE without END moves to ERR with code 1. `prog_len`=0 does the same immediately after WINIT.
- WRES: on the first edge with `calc_ready`=1, `result_q` ← `calc_result`, then go to DONE.
- Timeout:
  - A counter clears on each handshake and on each state entry.
  - Reaching `TIMEOUT` cycles in WINIT, ISSUE or WRES moves to ERR with code 2.
- `start` while busy is ignored. `prog_we` while busy is ignored.
- Arithmetic: the driver does not compute, except under the configuration macro below.

## Timing
- Reset values:
  - `calc_in`=0, `calc_reset`=1, `busy`=0, `done`=0, `error`=0, `err_code`=0, `result_q`=0.
  - State IDLE, `ptr`=0.
  - Program memory is not reset.
- `calc_reset` is 1 during `reset` and in CRST. In IDLE it holds the last value: 0 after DONE, 1 after ERR.
- Sequence from `start`:
  - Edge of `start`: go to CRST.
  - +1 cycle: go to WINIT, `calc_in`=`mem[0]`.
  - Token issue begins after the first `calc_ready`.
- `done` is asserted the cycle after `result_q` is loaded. `busy` falls in the same cycle.
- `reset` mid-run: the next edge forces IDLE with reset values. No `done` or `error` is produced.
- `start` and `prog_we` in the same cycle in IDLE: the write completes, and the run uses the new contents.

## Configuration
- `ORDINATOR_SEQ_CHECK_EN` defined:
  - Adds an internal golden model: an 8-bit modulo-256 accumulator.
  - The first operand loads it. Add and sub apply to the following operand. Invalid operators are ignored.
  - Adds output `mismatch` (1 bit, reset 0). It is set with `done` if `result_q` differs from the model value, and cleared on the next accepted `start`.
- Undefined: no model and no `mismatch` port.

## Structure
- Package `ordinator_pkg` holds:
  - Token constants `OP_ADD`=0, `OP_SUB`=1, `OP_END`=2.
  - The state enum.
  - The `err_code` constants.
- Sub-module `ordinator_prog_mem`: DEPTH×8 register file with synchronous write and asynchronous read.

## Test plan
- Program {10,0,12,2}, `prog_len`=4, run against `ordinator_8bit` → `done` pulse, `result_q`=22, `error`=0.
- Program {10,1,12,2} → `result_q`=254.
- Program {10,5,0,12,15,8,1,34,0,7,2} → `result_q`=251. With the macro defined, `mismatch`=0.
- Program {10,0,12}, `prog_len`=3 → `error`=1, `err_code`=1, `calc_reset`=1, no `done`.
- `calc_ready` tied 0, `TIMEOUT`=20 → ERR with `err_code`=2 exactly 20 cycles after WINIT entry.
- `reset` pulsed mid-ISSUE, then rerun the first program → no stale `done`; second run gives `result_q`=22. A `start` issued while busy has no effect.
